wb_irq_ctrl: RTL

Parametrised interrupt controller between device interrupt lines and the multi-cycle CPU's `INT`/`Cause_in` inputs. It replaces the fixed-priority OR/mux in the SoC top with a Wishbone slave on the intercon.
- Per-channel pending latches, level or edge mode per channel, and a mask register.
- A registered highest-priority cause, so software can read, mask and clear sources over the bus.

---
 rtl/wb_irq_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/wb_irq_ctrl.sv
// Wishbone-mapped interrupt controller: per-channel pending latches (level/edge), mask,
// registered priority cause. Define IRQ_SYNC_EN to add a two-flop synchronizer on irq.
module wb_irq_ctrl #(
  parameter int unsigned N_IRQ      = 6,
  parameter logic [31:0] RESET_MASK = 32'h0000_0000,
  parameter logic [31:0] RESET_EDGE = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic [N_IRQ-1:0] irq,
  input  logic             STB,
  input  logic             WE,
  input  logic [31:0]      ADDR,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  output logic             ACK,
  output logic             INT,
  output logic [31:0]      CAUSE
);

  logic [N_IRQ-1:0] s_q, s_prev_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] edge_q, edge_d;
  logic [N_IRQ-1:0] clr_s, active_s;
  logic             ack_q, int_q, int_d;
  logic [4:0]       cause_q, cause_d;
  logic [31:0]      dat_q, rd_s;
  logic             fire_s, wr_s;
  logic             unused_s;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] meta_q;

  // Two-flop synchronizer for asynchronous interrupt sources
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      meta_q <= '0;
      s_q    <= '0;
    end else begin
      meta_q <= irq;
      s_q    <= meta_q;
    end
  end
`else
  // Single sample stage; sources are already synchronous to clk
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      s_q <= '0;
    end else begin
      s_q <= irq;
    end
  end
`endif

  // An access fires once per STB assertion, in the first cycle ACK is still low
  assign fire_s = STB & ~ack_q;
  assign wr_s   = fire_s & WE;

  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    clr_s  = '0;
    if (wr_s) begin
      case (ADDR[3:2])
        2'd0:    clr_s  = DAT_I[N_IRQ-1:0];
        2'd1:    mask_d = DAT_I[N_IRQ-1:0];
        2'd3:    edge_d = DAT_I[N_IRQ-1:0];
        default: clr_s  = '0;
      endcase
    end else begin
      clr_s = '0;
    end
  end

  // Edge channels: a new rising edge beats a simultaneous W1C clear
  assign pending_d = (edge_q & ((s_q & ~s_prev_q) | (pending_q & ~clr_s)))
                   | (~edge_q & s_q);

  always_comb begin
    active_s = pending_d & mask_d;
    int_d    = |active_s;
    cause_d  = 5'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      cause_d = active_s[i] ? 5'(i) : cause_d;
    end
  end

  always_comb begin
    rd_s = 32'd0;
    case (ADDR[3:2])
      2'd0:    rd_s[N_IRQ-1:0] = pending_q;
      2'd1:    rd_s[N_IRQ-1:0] = mask_q;
      2'd2:    rd_s = {int_q, 26'd0, cause_q};
      2'd3:    rd_s[N_IRQ-1:0] = edge_q;
      default: rd_s = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      s_prev_q  <= '0;
      pending_q <= '0;
      mask_q    <= RESET_MASK[N_IRQ-1:0];
      edge_q    <= RESET_EDGE[N_IRQ-1:0];
      ack_q     <= 1'b0;
      dat_q     <= 32'd0;
      int_q     <= 1'b0;
      cause_q   <= 5'd0;
    end else begin
      s_prev_q  <= s_q;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      ack_q     <= STB;
      dat_q     <= fire_s ? rd_s : dat_q;
      int_q     <= int_d;
      cause_q   <= cause_d;
    end
  end

  assign DAT_O    = dat_q;
  assign ACK      = ack_q;
  assign INT      = int_q;
  assign CAUSE    = {27'd0, cause_q};
  assign unused_s = ^{ADDR[31:4], ADDR[1:0], DAT_I};

endmodule
